sc_core_oz_rf_arb: RTL and testbench

Write-port arbiter and sequencer for the single-cycle core's 31-entry register file (x1..x31; x0 hard-wired zero).
- Shares the single RF write port between three sources: core writeback, a debug valid/ready port, and an internal clear sequencer that sweeps x1..x31 after reset or on request.
- Drives the RF debug read address and returns read data with a fixed one-cycle latency.
- Stalls the core whenever it takes the write port away from it.

---
 rtl/sc_core_oz_pkg.sv | 19 +
 rtl/sc_core_oz_rf_clr_seq.sv | 46 ++++
 rtl/sc_core_oz_rf_arb.sv | 136 +++++++++++++
 tb/tb_sc_core_oz_rf_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_core_oz_pkg.sv
// Shared types and constants for the single-cycle core register-file write-port arbiter.
package sc_core_oz_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;
   localparam logic [RF_ADDR_W-1:0] RF_LAST_IDX = 5'd31;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } t_rf_arb_state;

   typedef struct packed {
      logic                 en;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } t_rf_wr_req;

endpackage

// File: rtl/sc_core_oz_rf_clr_seq.sv
// Clear sweep sequencer: owns the IDLE/CLEAR state, walks the pointer x1..x31 and pulses done
// one cycle after the last write.
module sc_core_oz_rf_clr_seq
   import sc_core_oz_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output t_rf_arb_state        state,
   output logic [RF_ADDR_W-1:0] ptr,
   output logic                 busy,
   output logic                 done
);

   t_rf_arb_state        state_q;
   logic [RF_ADDR_W-1:0] ptr_q;
   logic                 done_q;

   // start is only honoured from IDLE; a sweep always runs to x31 unless reset intervenes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         ptr_q   <= RF_ADDR_W'(1);
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == S_IDLE) begin
            if (start) state_q <= S_CLEAR;
         end else if (ptr_q == RF_LAST_IDX) begin
            state_q <= S_IDLE;
            ptr_q   <= RF_ADDR_W'(1);
            done_q  <= 1'b1;
         end else begin
            ptr_q <= ptr_q + RF_ADDR_W'(1);
         end
      end
   end

   assign state = state_q;
   assign ptr   = ptr_q;
   assign busy  = (state_q == S_CLEAR);
   assign done  = done_q;

endmodule

// File: rtl/sc_core_oz_rf_arb.sv
// RF write-port arbiter (clear sweep > core > debug write, with starvation relief) and debug read path.
// Optional perf counters are built when SC_CORE_OZ_RF_ARB_PERF_EN is defined.
module sc_core_oz_rf_arb
   import sc_core_oz_pkg::*;
#(
   parameter bit                      CLEAR_ON_RESET = 1'b1,
   parameter logic [RF_DATA_W-1:0]    CLEAR_VALUE    = 32'h0,
   parameter int unsigned             STARVE_LIMIT   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 core_wr_en,
   input  logic [RF_ADDR_W-1:0] core_wr_addr,
   input  logic [RF_DATA_W-1:0] core_wr_data,
   output logic                 core_stall,
   input  logic                 dbg_req_valid,
   output logic                 dbg_req_ready,
   input  logic                 dbg_req_we,
   input  logic [RF_ADDR_W-1:0] dbg_req_addr,
   input  logic [RF_DATA_W-1:0] dbg_req_wdata,
   output logic                 dbg_rsp_valid,
   output logic [RF_DATA_W-1:0] dbg_rsp_rdata,
   output logic [RF_ADDR_W-1:0] rf_dbg_rd_addr,
   input  logic [RF_DATA_W-1:0] rf_dbg_rd_data,
   input  logic                 clr_start,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic                 rf_wr_en,
   output logic [RF_ADDR_W-1:0] rf_wr_addr,
   output logic [RF_DATA_W-1:0] rf_wr_data
`ifdef SC_CORE_OZ_RF_ARB_PERF_EN
   ,
   output logic [15:0]          perf_dbg_wait,
   output logic [15:0]          perf_starve_cnt
`endif
);

   localparam int unsigned STARVE_W = 8;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   t_rf_arb_state        state;
   logic [RF_ADDR_W-1:0] clr_ptr;
   logic [STARVE_W-1:0]  starve_q;
   logic [STARVE_W-1:0]  starve_d;
   logic                 is_idle;
   logic                 core_ok;
   logic                 dbg_wr;
   logic                 dbg_rd;
   logic                 force_grant;
   logic                 dbg_grant;
   t_rf_wr_req           wr;

   sc_core_oz_rf_clr_seq #(
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clr_seq (
      .clk   (clk),
      .rst   (rst),
      .start (clr_start),
      .state (state),
      .ptr   (clr_ptr),
      .busy  (clr_busy),
      .done  (clr_done)
   );

   // Write-port mux; reset gating keeps the combinational outputs quiet while rst is low
   always_comb begin
      is_idle     = (state == S_IDLE);
      core_ok     = core_wr_en && (core_wr_addr != '0);
      dbg_wr      = dbg_req_valid && dbg_req_we;
      dbg_rd      = dbg_req_valid && !dbg_req_we;
      force_grant = is_idle && dbg_wr && (starve_q == STARVE_MAX);
      dbg_grant   = is_idle && dbg_wr && (!core_ok || force_grant);
      starve_d    = (is_idle && dbg_wr && !dbg_grant) ? starve_q + STARVE_W'(1) : '0;

      wr = '0;
      if (!is_idle) begin
         wr.en   = 1'b1;
         wr.addr = clr_ptr;
         wr.data = CLEAR_VALUE;
      end else if (core_ok && !force_grant) begin
         wr.en   = 1'b1;
         wr.addr = core_wr_addr;
         wr.data = core_wr_data;
      end else if (dbg_grant) begin
         wr.en   = 1'b1;
         wr.addr = dbg_req_addr;
         wr.data = dbg_req_wdata;
      end
      if (wr.addr == '0) wr.en = 1'b0;
      if (!rst) wr = '0;

      dbg_req_ready = rst && is_idle && (dbg_req_we ? (!core_ok || force_grant) : 1'b1);
      core_stall    = !is_idle || force_grant;
   end

   assign rf_wr_en       = wr.en;
   assign rf_wr_addr     = wr.addr;
   assign rf_wr_data     = wr.data;
   assign rf_dbg_rd_addr = dbg_req_addr;

   // Starve counter and one-cycle read response; data sampled before any same-cycle write lands
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q      <= '0;
         dbg_rsp_valid <= 1'b0;
         dbg_rsp_rdata <= '0;
      end else begin
         starve_q      <= starve_d;
         dbg_rsp_valid <= is_idle && dbg_rd;
         if (is_idle && dbg_rd) begin
            dbg_rsp_rdata <= (dbg_req_addr == '0) ? '0 : rf_dbg_rd_data;
         end
      end
   end

`ifdef SC_CORE_OZ_RF_ARB_PERF_EN
   // Saturating perf counters, zeroed by reset or any clr_start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_dbg_wait   <= '0;
         perf_starve_cnt <= '0;
      end else if (clr_start) begin
         perf_dbg_wait   <= '0;
         perf_starve_cnt <= '0;
      end else begin
         if (dbg_wr && !dbg_req_ready && (perf_dbg_wait != 16'hFFFF)) begin
            perf_dbg_wait <= perf_dbg_wait + 16'd1;
         end
         if (force_grant && (perf_starve_cnt != 16'hFFFF)) begin
            perf_starve_cnt <= perf_starve_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sc_core_oz_rf_arb.sv
// Directed self-checking bench for sc_core_oz_rf_arb; models the register file around the DUT.
// Perf counter checks are included when SC_CORE_OZ_RF_ARB_PERF_EN is defined.
module tb_sc_core_oz_rf_arb;

   logic        clk;
   logic        rst;
   logic        core_wr_en;
   logic [4:0]  core_wr_addr;
   logic [31:0] core_wr_data;
   logic        core_stall;
   logic        dbg_req_valid;
   logic        dbg_req_ready;
   logic        dbg_req_we;
   logic [4:0]  dbg_req_addr;
   logic [31:0] dbg_req_wdata;
   logic        dbg_rsp_valid;
   logic [31:0] dbg_rsp_rdata;
   logic [4:0]  rf_dbg_rd_addr;
   logic [31:0] rf_dbg_rd_data;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_done;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
`ifdef SC_CORE_OZ_RF_ARB_PERF_EN
   logic [15:0] perf_dbg_wait;
   logic [15:0] perf_starve_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] rf_mem [32];

   sc_core_oz_rf_arb #(
      .CLEAR_ON_RESET (1'b1),
      .CLEAR_VALUE    (32'hDEAD_BEEF),
      .STARVE_LIMIT   (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .core_wr_en     (core_wr_en),
      .core_wr_addr   (core_wr_addr),
      .core_wr_data   (core_wr_data),
      .core_stall     (core_stall),
      .dbg_req_valid  (dbg_req_valid),
      .dbg_req_ready  (dbg_req_ready),
      .dbg_req_we     (dbg_req_we),
      .dbg_req_addr   (dbg_req_addr),
      .dbg_req_wdata  (dbg_req_wdata),
      .dbg_rsp_valid  (dbg_rsp_valid),
      .dbg_rsp_rdata  (dbg_rsp_rdata),
      .rf_dbg_rd_addr (rf_dbg_rd_addr),
      .rf_dbg_rd_data (rf_dbg_rd_data),
      .clr_start      (clr_start),
      .clr_busy       (clr_busy),
      .clr_done       (clr_done),
      .rf_wr_en       (rf_wr_en),
      .rf_wr_addr     (rf_wr_addr),
      .rf_wr_data     (rf_wr_data)
`ifdef SC_CORE_OZ_RF_ARB_PERF_EN
      ,
      .perf_dbg_wait   (perf_dbg_wait),
      .perf_starve_cnt (perf_starve_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Register file model; its x0 read port returns junk so the DUT's zero forcing is visible
   always @(posedge clk) begin
      if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
   end
   assign rf_dbg_rd_data = (rf_dbg_rd_addr == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_dbg_rd_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full 31-write sweep starting now (time = posedge+1 of sweep cycle 1), then the done pulse
   task automatic sweep_check();
      for (int i = 1; i <= 31; i++) begin
         #1;
         chk("sweep_en", rf_wr_en, 1);
         chk("sweep_addr", rf_wr_addr, i);
         chk("sweep_data", rf_wr_data, 32'hDEAD_BEEF);
         chk("sweep_stall", core_stall, 1);
         chk("sweep_done_early", clr_done, 0);
         tick();
      end
      #1;
      chk("sweep_done", clr_done, 1);
      chk("sweep_busy_off", clr_busy, 0);
      chk("sweep_stall_off", core_stall, 0);
      chk("sweep_wr_off", rf_wr_en, 0);
      tick();
      chk("done_pulse", clr_done, 0);
   endtask

   task automatic dbg_read(input logic [4:0] a, input logic [31:0] exp);
      dbg_req_valid = 1'b1;
      dbg_req_we    = 1'b0;
      dbg_req_addr  = a;
      #1;
      chk("rd_ready", dbg_req_ready, 1);
      chk("rd_addr", rf_dbg_rd_addr, a);
      tick();
      dbg_req_valid = 1'b0;
      chk("rsp_valid", dbg_rsp_valid, 1);
      chk("rsp_data", dbg_rsp_rdata, exp);
      tick();
      chk("rsp_pulse", dbg_rsp_valid, 0);
   endtask

   // Core writes x7 every cycle while a debug write waits: 8 blocked cycles, then a forced grant
   task automatic starve_run(input logic [4:0] da, input logic [31:0] dd);
      core_wr_en    = 1'b1;
      core_wr_addr  = 5'd7;
      core_wr_data  = 32'h77;
      dbg_req_valid = 1'b1;
      dbg_req_we    = 1'b1;
      dbg_req_addr  = da;
      dbg_req_wdata = dd;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("starve_ready", dbg_req_ready, 0);
         chk("starve_stall", core_stall, 0);
         chk("starve_core_addr", rf_wr_addr, 5'd7);
         tick();
      end
      #1;
      chk("force_stall", core_stall, 1);
      chk("force_ready", dbg_req_ready, 1);
      chk("force_addr", rf_wr_addr, da);
      chk("force_data", rf_wr_data, dd);
      tick();
      dbg_req_valid = 1'b0;
      dbg_req_we    = 1'b0;
      core_wr_en    = 1'b0;
      #1;
      chk("after_force_stall", core_stall, 0);
      tick();
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      core_wr_en = 1'b0;
      core_wr_addr = '0;
      core_wr_data = '0;
      dbg_req_valid = 1'b0;
      dbg_req_we = 1'b0;
      dbg_req_addr = '0;
      dbg_req_wdata = '0;
      clr_start = 1'b0;
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;

      // Reset values
      tick();
      tick();
      chk("rst_stall", core_stall, 1);
      chk("rst_busy", clr_busy, 1);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_ready", dbg_req_ready, 0);
      chk("rst_rsp", dbg_rsp_valid, 0);
      chk("rst_done", clr_done, 0);

      // Automatic sweep on reset release
      rst = 1'b1;
      sweep_check();
      dbg_read(5'd17, 32'hDEAD_BEEF);

      // Core beats a same-cycle debug write; debug lands next cycle
      core_wr_en = 1'b1;
      core_wr_addr = 5'd5;
      core_wr_data = 32'h11;
      dbg_req_valid = 1'b1;
      dbg_req_we = 1'b1;
      dbg_req_addr = 5'd6;
      dbg_req_wdata = 32'h22;
      #1;
      chk("prio_addr", rf_wr_addr, 5'd5);
      chk("prio_data", rf_wr_data, 32'h11);
      chk("prio_ready", dbg_req_ready, 0);
      tick();
      core_wr_en = 1'b0;
      #1;
      chk("dbgwr_ready", dbg_req_ready, 1);
      chk("dbgwr_addr", rf_wr_addr, 5'd6);
      chk("dbgwr_data", rf_wr_data, 32'h22);
      tick();

      // Back-to-back reads give back-to-back responses
      dbg_req_we = 1'b0;
      dbg_req_addr = 5'd6;
      tick();
      chk("b2b_rsp0_v", dbg_rsp_valid, 1);
      chk("b2b_rsp0_d", dbg_rsp_rdata, 32'h22);
      dbg_req_addr = 5'd5;
      tick();
      dbg_req_valid = 1'b0;
      chk("b2b_rsp1_v", dbg_rsp_valid, 1);
      chk("b2b_rsp1_d", dbg_rsp_rdata, 32'h11);
      tick();

      // Starvation relief
      starve_run(5'd8, 32'h88);
      dbg_read(5'd8, 32'h88);
      dbg_read(5'd7, 32'h77);

      // x0 write is dropped, x0 read returns zero
      dbg_req_valid = 1'b1;
      dbg_req_we = 1'b1;
      dbg_req_addr = 5'd0;
      dbg_req_wdata = 32'hFFFF_FFFF;
      #1;
      chk("x0_ready", dbg_req_ready, 1);
      chk("x0_wr_en", rf_wr_en, 0);
      tick();
      dbg_read(5'd0, 32'h0);

      // clr_start with a same-cycle read, then abort the sweep with reset at pointer 20
      clr_start = 1'b1;
      dbg_req_valid = 1'b1;
      dbg_req_we = 1'b0;
      dbg_req_addr = 5'd6;
      #1;
      chk("start_rd_ready", dbg_req_ready, 1);
      tick();
      clr_start = 1'b0;
      dbg_req_valid = 1'b0;
      chk("start_rsp_v", dbg_rsp_valid, 1);
      chk("start_rsp_d", dbg_rsp_rdata, 32'h22);
      chk("start_busy", clr_busy, 1);
      for (int i = 1; i < 20; i++) begin
         clr_start = (i == 12);
         core_wr_en = (i == 12);
         core_wr_addr = 5'd9;
         #1;
         chk("abort_addr", rf_wr_addr, i);
         chk("abort_en", rf_wr_en, 1);
         tick();
      end
      clr_start = 1'b0;
      core_wr_en = 1'b0;
      #1;
      chk("abort_addr20", rf_wr_addr, 5'd20);
      rst = 1'b0;
      #1;
      chk("abort_rst_en", rf_wr_en, 0);
      chk("abort_rst_busy", clr_busy, 1);
      chk("abort_rst_stall", core_stall, 1);
      tick();
      rst = 1'b1;
      sweep_check();
      dbg_read(5'd6, 32'hDEAD_BEEF);

`ifdef SC_CORE_OZ_RF_ARB_PERF_EN
      // clr_start zeroes the counters; two starve runs give 2 forced stalls and 16 wait cycles
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      chk("perf_clr_wait", perf_dbg_wait, 0);
      chk("perf_clr_starve", perf_starve_cnt, 0);
      for (int i = 0; i < 40 && clr_busy; i++) tick();
      chk("perf_sweep_end", clr_busy, 0);
      tick();
      starve_run(5'd10, 32'hA0);
      starve_run(5'd11, 32'hB0);
      chk("perf_starve", perf_starve_cnt, 2);
      chk("perf_wait", perf_dbg_wait, 16);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
